// File: rtl/tpsram_fifo_ctrl.sv
// FIFO controller in front of a two-port SRAM with a 1-cycle registered read.
// The SRAM output register doubles as the first-word-fall-through output entry.
module tpsram_fifo_ctrl #(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned DEPTH_LOG = $clog2(DEPTH),
    parameter int unsigned AFULL     = DEPTH - 2,
    localparam int unsigned CNT_W    = $clog2(DEPTH + 2)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [WIDTH-1:0]     s_data,
    output logic                 s_afull,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [WIDTH-1:0]     m_data,
    output logic [CNT_W-1:0]     count,
    output logic                 mem_we,
    output logic [DEPTH_LOG-1:0] mem_wa,
    output logic [WIDTH-1:0]     mem_wd,
    output logic                 mem_re,
    output logic [DEPTH_LOG-1:0] mem_ra,
    input  logic [WIDTH-1:0]     mem_rd
);

    localparam int unsigned SCNT_W = $clog2(DEPTH + 1);

    logic [DEPTH_LOG-1:0] wptr_q, wptr_d;
    logic [DEPTH_LOG-1:0] rptr_q, rptr_d;
    logic [SCNT_W-1:0]    sram_cnt_q, sram_cnt_d;
    logic                 out_vld_q, out_vld_d;
    logic                 accept;

    always_comb begin
        s_ready = !rst && (sram_cnt_q < SCNT_W'(DEPTH));
        accept  = s_valid && s_ready;
        // Refill the output entry whenever it is empty or being consumed this cycle.
        mem_re  = !rst && (sram_cnt_q != '0) && (!out_vld_q || m_ready);

        mem_we  = accept;
        mem_wa  = wptr_q;
        mem_wd  = s_data;
        mem_ra  = rptr_q;

        m_valid = out_vld_q;
        m_data  = mem_rd;

        count   = CNT_W'(sram_cnt_q) + CNT_W'(out_vld_q);
        s_afull = (count >= CNT_W'(AFULL));
    end

    always_comb begin
        wptr_d = wptr_q;
        if (accept) begin
            wptr_d = (wptr_q == DEPTH_LOG'(DEPTH - 1)) ? '0 : wptr_q + DEPTH_LOG'(1);
        end

        rptr_d = rptr_q;
        if (mem_re) begin
            rptr_d = (rptr_q == DEPTH_LOG'(DEPTH - 1)) ? '0 : rptr_q + DEPTH_LOG'(1);
        end

        sram_cnt_d = sram_cnt_q + SCNT_W'(accept) - SCNT_W'(mem_re);

        out_vld_d = out_vld_q;
        if (mem_re) begin
            out_vld_d = 1'b1;
        end else if (m_ready) begin
            out_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            sram_cnt_q <= '0;
            out_vld_q  <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            sram_cnt_q <= sram_cnt_d;
            out_vld_q  <= out_vld_d;
        end
    end

endmodule

// File: tb/tb_tpsram_fifo_ctrl.sv
// Directed bench for tpsram_fifo_ctrl with a behavioural SRAM and an ordering scoreboard.
module tb_tpsram_fifo_ctrl;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned WIDTH = 32;
    localparam int unsigned AW    = 3;
    localparam int unsigned CW    = 4;

    logic             clk;
    logic             rst;
    logic             s_valid;
    logic             s_ready;
    logic [WIDTH-1:0] s_data;
    logic             s_afull;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;
    logic [CW-1:0]    count;
    logic             mem_we;
    logic [AW-1:0]    mem_wa;
    logic [WIDTH-1:0] mem_wd;
    logic             mem_re;
    logic [AW-1:0]    mem_ra;
    logic [WIDTH-1:0] mem_rd;

    int checks   = 0;
    int failures = 0;

    tpsram_fifo_ctrl #(
        .DEPTH(DEPTH),
        .WIDTH(WIDTH)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .s_data (s_data),
        .s_afull(s_afull),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_data (m_data),
        .count  (count),
        .mem_we (mem_we),
        .mem_wa (mem_wa),
        .mem_wd (mem_wd),
        .mem_re (mem_re),
        .mem_ra (mem_ra),
        .mem_rd (mem_rd)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Two-port SRAM with registered read; output holds while mem_re is low.
    logic [WIDTH-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (mem_we) mem[mem_wa] <= mem_wd;
        if (mem_re) mem_rd <= mem[mem_ra];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: order, occupancy and backpressure stability, sampled at each edge.
    bit               sb_en = 0;
    logic [WIDTH-1:0] q [$];
    bit               bp_q = 0;
    logic [WIDTH-1:0] bp_data;
    logic [WIDTH-1:0] exp_w;

    always @(posedge clk) begin
        if (sb_en && !rst) begin
            check("sb_count", 32'(count), 32'(q.size()));
            if (bp_q) begin
                check("bp_valid", 32'(m_valid), 32'd1);
                check("bp_data", m_data, bp_data);
            end
            if (m_valid && !m_ready) check("bp_no_re", 32'(mem_re), 32'd0);
            if (s_valid && s_ready) q.push_back(s_data);
            if (m_valid && m_ready) begin
                if (q.size() == 0) begin
                    check("sb_underflow", 32'(q.size()), 32'd1);
                end else begin
                    exp_w = q.pop_front();
                    check("sb_data", m_data, exp_w);
                end
            end
            bp_q    = m_valid && !m_ready;
            bp_data = m_data;
        end else begin
            if (rst) q.delete();
            bp_q = 0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst     = 1'b1;
        s_valid = 1'b1;
        s_data  = 32'hDEAD_BEEF;
        m_ready = 1'b1;
        tick();
        tick();
        check("rst_s_ready", 32'(s_ready), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_re", 32'(mem_re), 32'd0);
        rst     = 1'b0;
        s_valid = 1'b0;
        m_ready = 1'b0;
        #1;
        check("post_rst_m_valid", 32'(m_valid), 32'd0);
        check("post_rst_count", 32'(count), 32'd0);
        check("post_rst_s_afull", 32'(s_afull), 32'd0);
        check("post_rst_s_ready", 32'(s_ready), 32'd1);
        sb_en = 1;

        // Single word: m_valid two cycles after the accepting edge.
        s_valid = 1'b1;
        s_data  = 32'hA5A5_0001;
        #1;
        check("single_we", 32'(mem_we), 32'd1);
        check("single_wa", 32'(mem_wa), 32'd0);
        check("single_wd", mem_wd, 32'hA5A5_0001);
        tick();
        s_valid = 1'b0;
        #1;
        check("single_count1", 32'(count), 32'd1);
        check("single_re", 32'(mem_re), 32'd1);
        check("single_valid_n1", 32'(m_valid), 32'd0);
        tick();
        check("single_valid_n2", 32'(m_valid), 32'd1);
        check("single_data", m_data, 32'hA5A5_0001);
        check("single_count2", 32'(count), 32'd1);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        #1;
        check("single_count0", 32'(count), 32'd0);
        check("single_valid_off", 32'(m_valid), 32'd0);

        // Fill with the output stalled: nine words fit, the tenth is refused.
        for (int i = 0; i < 10; i++) begin
            s_valid = 1'b1;
            s_data  = 32'(i);
            #1;
            check("fill_count", 32'(count), 32'(i));
            check("fill_afull", 32'(s_afull), 32'(i >= 6));
            check("fill_ready", 32'(s_ready), 32'(i < 9));
            tick();
        end
        s_valid = 1'b0;
        #1;
        check("full_count", 32'(count), 32'd9);
        check("full_ready", 32'(s_ready), 32'd0);

        // Drain: first pop issues mem_re, s_ready rises one cycle later.
        m_ready = 1'b1;
        for (int j = 0; j < 9; j++) begin
            #1;
            check("drain_valid", 32'(m_valid), 32'd1);
            check("drain_data", m_data, 32'(j));
            if (j == 0) begin
                check("drain_ready0", 32'(s_ready), 32'd0);
                check("drain_re0", 32'(mem_re), 32'd1);
            end
            if (j == 1) check("drain_ready1", 32'(s_ready), 32'd1);
            tick();
        end
        #1;
        check("drain_empty_valid", 32'(m_valid), 32'd0);
        check("drain_empty_count", 32'(count), 32'd0);

        // Streaming through pointer wrap.
        for (int i = 0; i < 20; i++) begin
            s_valid = 1'b1;
            s_data  = 32'h100 + 32'(i);
            #1;
            check("stream_count_le2", 32'(count <= 4'd2), 32'd1);
            if (i >= 2) begin
                check("stream_valid", 32'(m_valid), 32'd1);
                check("stream_data", m_data, 32'h100 + 32'(i - 2));
            end
            tick();
        end
        s_valid = 1'b0;
        repeat (3) tick();
        check("stream_drained", 32'(count), 32'd0);

        // Random valid/ready mix; the scoreboard checks order and stability.
        for (int i = 0; i < 60; i++) begin
            s_valid = 1'($urandom_range(0, 1));
            s_data  = $urandom;
            m_ready = ($urandom_range(0, 3) == 0);
            tick();
        end

        // Refill to full, then push and pop together.
        s_valid = 1'b1;
        m_ready = 1'b0;
        begin
            int guard;
            guard = 0;
            while (count != 4'd9 && guard < 30) begin
                s_data = $urandom;
                tick();
                guard++;
            end
            check("refill_reached_full", 32'(count), 32'd9);
        end
        m_ready = 1'b1;
        s_data  = 32'hF00D_0000;
        #1;
        check("fullpp_ready0", 32'(s_ready), 32'd0);
        check("fullpp_re", 32'(mem_re), 32'd1);
        tick();
        check("fullpp_ready1", 32'(s_ready), 32'd1);
        for (int i = 0; i < 100; i++) begin
            s_valid = 1'($urandom_range(0, 1));
            s_data  = $urandom;
            m_ready = 1'($urandom_range(0, 1));
            tick();
        end

        // Reset with five words queued, then confirm a fresh word comes out first.
        s_valid = 1'b0;
        m_ready = 1'b1;
        repeat (12) tick();
        check("pre_rst_empty", 32'(count), 32'd0);
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            s_valid = 1'b1;
            s_data  = 32'hBB00 + 32'(i);
            tick();
        end
        check("pre_rst_count5", 32'(count), 32'd5);
        rst     = 1'b1;
        s_valid = 1'b1;
        m_ready = 1'b1;
        tick();
        rst     = 1'b0;
        s_valid = 1'b0;
        m_ready = 1'b0;
        #1;
        check("midrst_valid", 32'(m_valid), 32'd0);
        check("midrst_count", 32'(count), 32'd0);
        check("midrst_ready", 32'(s_ready), 32'd1);
        s_valid = 1'b1;
        s_data  = 32'h0000_1234;
        tick();
        s_valid = 1'b0;
        tick();
        check("midrst_first_valid", 32'(m_valid), 32'd1);
        check("midrst_first_data", m_data, 32'h0000_1234);
        m_ready = 1'b1;
        tick();
        check("midrst_final_count", 32'(count), 32'd0);

        sb_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
